// File: rtl/spell_loader_pkg.sv
// Shared types and constants for the spell boot loader.
// Includes the CRC-8 step used when SPELL_LOADER_CRC_EN is defined.
package spell_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StSetup,
        StCmd,
        StData,
        StHold,
        StDone
    } state_e;

    localparam logic [7:0]  SPI_READ_CMD = 8'h03;
    localparam int unsigned CMD_BITS     = 32;
    localparam int unsigned NBITS_W      = $clog2(CMD_BITS + 1);
    localparam logic [7:0]  CRC8_POLY    = 8'h07;

    // One byte of MSB-first CRC-8, no reflection.
    function automatic logic [7:0] crc8_update(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) begin
            c = c[7] ? ((c << 1) ^ CRC8_POLY) : (c << 1);
        end
        return c;
    endfunction

endpackage

// File: rtl/spell_spi_shifter.sv
// SPI mode-0 bit engine: SCK divider plus up-to-32-bit shift.
// A go pulse is itself the first rising edge; each bit is a high half then a low half.
module spell_spi_shifter
    import spell_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_go,
    input  logic [NBITS_W-1:0]  i_nbits,
    input  logic [CMD_BITS-1:0] i_tx,
    input  logic                i_miso,
    output logic                o_sck,
    output logic                o_mosi,
    output logic [7:0]          o_rx,
    output logic                o_bit_done,
    output logic                o_byte_done
);

    localparam int unsigned   CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(CLK_DIV - 1);

    logic                r_active;
    logic                r_sck;
    logic [CW-1:0]       r_cnt;
    logic [NBITS_W-1:0]  r_bits;
    logic [2:0]          r_bit_idx;
    logic [CMD_BITS-1:0] r_tx;
    logic [7:0]          r_rx;

    logic w_tick;
    logic w_low_end;
    logic w_cont_rise;

    assign w_tick      = r_active && (r_cnt == CNT_MAX);
    assign w_low_end   = w_tick && !r_sck;
    assign w_cont_rise = w_low_end && (r_bits != NBITS_W'(1));

    // o_bit_done: all requested bits shifted; o_byte_done: this edge samples an 8th bit.
    assign o_bit_done  = w_low_end && (r_bits == NBITS_W'(1));
    assign o_byte_done = w_cont_rise && (r_bit_idx == 3'd7);
    assign o_rx        = {r_rx[6:0], i_miso};
    assign o_sck       = r_sck;
    assign o_mosi      = r_tx[CMD_BITS-1];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_active  <= 1'b0;
            r_sck     <= 1'b0;
            r_cnt     <= '0;
            r_bits    <= '0;
            r_bit_idx <= '0;
            r_tx      <= '0;
            r_rx      <= '0;
        end else if (i_go) begin
            r_active  <= 1'b1;
            r_sck     <= 1'b1;
            r_cnt     <= '0;
            r_bits    <= i_nbits;
            r_bit_idx <= 3'd1;
            r_tx      <= i_tx;
            r_rx      <= o_rx;
        end else if (!r_active) begin
            // Track the tx word while idle so its MSB is on MOSI before the first edge.
            r_tx <= i_tx;
        end else if (w_tick) begin
            r_cnt <= '0;
            if (r_sck) begin
                r_sck <= 1'b0;
                r_tx  <= r_tx << 1;
            end else if (r_bits == NBITS_W'(1)) begin
                r_active <= 1'b0;
            end else begin
                r_sck     <= 1'b1;
                r_bits    <= r_bits - NBITS_W'(1);
                r_bit_idx <= r_bit_idx + 3'd1;
                r_rx      <= o_rx;
            end
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

endmodule

// File: rtl/spell_flash_loader.sv
// Boot loader: reads a spell image from SPI flash (READ 0x03) into program memory.
// Define SPELL_LOADER_CRC_EN to get a CRC-8 of the loaded bytes on crc_o.
module spell_flash_loader
    import spell_loader_pkg::*;
#(
    parameter int unsigned CLK_DIV = 2,
    parameter int unsigned MEM_AW  = 8
) (
    input  logic              wb_clk_i,
    input  logic              wb_rst_i,
    input  logic              start_i,
    input  logic [23:0]       base_addr_i,
    input  logic [MEM_AW:0]   len_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              spell_rst_o,
    output logic              mem_we_o,
    output logic [MEM_AW-1:0] mem_addr_o,
    output logic [7:0]        mem_wdata_o,
    output logic              flash_csb_o,
    output logic              flash_clk_o,
    output logic              flash_io0_o,
    input  logic              flash_io1_i,
    output logic [7:0]        crc_o
);

    localparam int unsigned     CW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0]   CNT_MAX = CW'(CLK_DIV - 1);
    localparam logic [MEM_AW:0] MAX_LEN = {1'b1, {MEM_AW{1'b0}}};

    state_e              r_state;
    state_e              w_state_d;
    logic [CW-1:0]       r_cnt;
    logic [23:0]         r_base;
    logic [MEM_AW:0]     r_len;
    logic [MEM_AW:0]     r_idx;
    logic                r_spell_rst;
    logic                r_mem_we;
    logic [MEM_AW-1:0]   r_mem_addr;
    logic [7:0]          r_mem_wdata;

    logic                w_start;
    logic                w_cnt_end;
    logic                w_go;
    logic [NBITS_W-1:0]  w_nbits;
    logic [CMD_BITS-1:0] w_tx;
    logic [7:0]          w_rx;
    logic                w_bit_done;
    logic                w_byte_done;

    assign w_start   = (r_state == StIdle) && start_i;
    assign w_cnt_end = (r_cnt == CNT_MAX);

    spell_spi_shifter #(
        .CLK_DIV(CLK_DIV)
    ) u_shifter (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_go       (w_go),
        .i_nbits    (w_nbits),
        .i_tx       (w_tx),
        .i_miso     (flash_io1_i),
        .o_sck      (flash_clk_o),
        .o_mosi     (flash_io0_o),
        .o_rx       (w_rx),
        .o_bit_done (w_bit_done),
        .o_byte_done(w_byte_done)
    );

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state <= StIdle;
        end else begin
            r_state <= w_state_d;
        end
    end

    always_comb begin
        w_state_d = r_state;
        unique case (r_state)
            StIdle:  if (start_i) w_state_d = (len_i == '0) ? StDone : StSetup;
            StSetup: if (w_cnt_end) w_state_d = StCmd;
            StCmd:   if (w_bit_done) w_state_d = StData;
            StData:  if (w_bit_done && (r_idx == r_len)) w_state_d = StHold;
            StHold:  if (w_cnt_end) w_state_d = StDone;
            StDone:  w_state_d = StIdle;
            default: w_state_d = StIdle;
        endcase
    end

    // Transfers are chained on the shifter's done strobe so SCK never pauses mid-load.
    always_comb begin
        busy_o      = 1'b0;
        done_o      = 1'b0;
        flash_csb_o = 1'b1;
        w_go        = 1'b0;
        w_nbits     = NBITS_W'(8);
        w_tx        = '0;
        unique case (r_state)
            StSetup: begin
                busy_o      = 1'b1;
                flash_csb_o = 1'b0;
                w_tx        = {SPI_READ_CMD, r_base};
                w_nbits     = NBITS_W'(CMD_BITS);
                w_go        = w_cnt_end;
            end
            StCmd: begin
                busy_o      = 1'b1;
                flash_csb_o = 1'b0;
                w_go        = w_bit_done;
            end
            StData: begin
                busy_o      = 1'b1;
                flash_csb_o = 1'b0;
                w_go        = w_bit_done && (r_idx != r_len);
            end
            StHold: begin
                busy_o      = 1'b1;
                flash_csb_o = 1'b0;
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_cnt       <= '0;
            r_base      <= '0;
            r_len       <= '0;
            r_idx       <= '0;
            r_spell_rst <= 1'b1;
            r_mem_we    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_mem_we <= 1'b0;
            if ((r_state == StSetup) || (r_state == StHold)) begin
                r_cnt <= w_cnt_end ? '0 : r_cnt + CW'(1);
            end else begin
                r_cnt <= '0;
            end
            if (w_start) begin
                r_base      <= base_addr_i;
                r_len       <= (len_i > MAX_LEN) ? MAX_LEN : len_i;
                r_idx       <= '0;
                r_spell_rst <= 1'b1;
            end
            if (w_state_d == StDone) begin
                r_spell_rst <= 1'b0;
            end
            if ((r_state == StData) && w_byte_done) begin
                r_mem_we    <= 1'b1;
                r_mem_addr  <= r_idx[MEM_AW-1:0];
                r_mem_wdata <= w_rx;
                r_idx       <= r_idx + (MEM_AW + 1)'(1);
            end
        end
    end

    assign spell_rst_o = r_spell_rst;
    assign mem_we_o    = r_mem_we;
    assign mem_addr_o  = r_mem_addr;
    assign mem_wdata_o = r_mem_wdata;

`ifdef SPELL_LOADER_CRC_EN
    logic [7:0] r_crc;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_crc <= '0;
        end else if (w_start) begin
            r_crc <= '0;
        end else if (r_mem_we) begin
            r_crc <= crc8_update(r_crc, r_mem_wdata);
        end
    end

    assign crc_o = r_crc;
`else
    assign crc_o = 8'h00;
`endif

endmodule

// File: tb/tb_spell_flash_loader.sv
// Bench for spell_flash_loader: SPI flash model, write scoreboard, vector table
// plus abort/restart and start-while-busy sequences.
module tb_spell_flash_loader;

    localparam int unsigned CLK_DIV = 2;
    localparam int unsigned MEM_AW  = 8;
    localparam int          TIMEOUT = 20000;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              start = 1'b0;
    logic [23:0]       base_addr = '0;
    logic [MEM_AW:0]   len = '0;
    logic              busy_o;
    logic              done_o;
    logic              spell_rst_o;
    logic              mem_we_o;
    logic [MEM_AW-1:0] mem_addr_o;
    logic [7:0]        mem_wdata_o;
    logic              flash_csb_o;
    logic              flash_clk_o;
    logic              flash_io0_o;
    logic              miso = 1'b0;
    logic [7:0]        crc_o;

    always #5 clk = ~clk;

    spell_flash_loader #(
        .CLK_DIV(CLK_DIV),
        .MEM_AW (MEM_AW)
    ) dut (
        .wb_clk_i   (clk),
        .wb_rst_i   (rst),
        .start_i    (start),
        .base_addr_i(base_addr),
        .len_i      (len),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .spell_rst_o(spell_rst_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_wdata_o(mem_wdata_o),
        .flash_csb_o(flash_csb_o),
        .flash_clk_o(flash_clk_o),
        .flash_io0_o(flash_io0_o),
        .flash_io1_i(miso),
        .crc_o      (crc_o)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, required %0h", name, act, exp);
    endtask

    // Flash contents: explicit bytes, otherwise an address-derived pattern.
    logic [7:0] flash_img [logic [23:0]];

    function automatic logic [7:0] flash_byte(input logic [23:0] a);
        if (flash_img.exists(a)) return flash_img[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    function automatic logic [7:0] crc8_ref(input logic [7:0] c, input logic [7:0] d);
        logic [7:0] r;
        r = c ^ d;
        for (int i = 0; i < 8; i++) r = r[7] ? ({r[6:0], 1'b0} ^ 8'h07) : {r[6:0], 1'b0};
        return r;
    endfunction

    // SPI mode-0 flash slave.
    int          spi_bits = 0;
    int          cs_falls = 0;
    logic [31:0] spi_cmd = '0;

    always @(negedge flash_csb_o) begin
        spi_bits = 0;
        cs_falls++;
    end

    always @(posedge flash_clk_o) begin
        if (!flash_csb_o) begin
            if (spi_bits < 32) spi_cmd = {spi_cmd[30:0], flash_io0_o};
            spi_bits++;
        end
    end

    always @(negedge flash_clk_o) begin : spi_tx
        int k;
        logic [7:0] b;
        k = spi_bits - 32;
        if (!flash_csb_o && k >= 0) begin
            b = flash_byte(spi_cmd[23:0] + 24'(k / 8));
            miso = b[7 - (k % 8)];
        end
    end

    // Scoreboard of expected memory writes.
    typedef struct packed {
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t  exp_q[$];
    int   n_writes = 0;
    logic sck_bad = 1'b0;

    always @(negedge clk) begin : wr_mon
        wr_t e;
        if (flash_csb_o && flash_clk_o) sck_bad = 1'b1;
        if (!rst && mem_we_o) begin
            n_writes++;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL write_unexpected: got addr %0h data %0h, required no write",
                         mem_addr_o, mem_wdata_o);
            end else begin
                e = exp_q.pop_front();
                check("write_addr", 32'(mem_addr_o), 32'(e.addr));
                check("write_data", 32'(mem_wdata_o), 32'(e.data));
                check("spell_rst_during_load", 32'(spell_rst_o), 32'd1);
            end
        end
    end

    typedef struct {
        logic [23:0]     base;
        logic [MEM_AW:0] len;
        int              exp_writes;
        int              exp_lat;
        int              poke_at;
    } vec_t;

    task automatic run_load(input vec_t v);
        int         nl;
        int         lat;
        int         w0;
        int         cs0;
        logic [7:0] crc;
        wr_t        e;
        nl  = (v.len > 9'd256) ? 256 : int'(v.len);
        crc = 8'h00;
        for (int i = 0; i < nl; i++) begin
            e.addr = 8'(i);
            e.data = flash_byte(v.base + 24'(i));
            crc    = crc8_ref(crc, e.data);
            exp_q.push_back(e);
        end
`ifndef SPELL_LOADER_CRC_EN
        crc = 8'h00;
`endif
        w0  = n_writes;
        cs0 = cs_falls;
        @(negedge clk);
        start     = 1'b1;
        base_addr = v.base;
        len       = v.len;
        @(negedge clk);
        start = 1'b0;
        lat   = 1;
        while (!done_o && lat < TIMEOUT) begin
            start = (lat == v.poke_at);
            if (start) begin
                base_addr = 24'h123456;
                len       = 9'd3;
            end
            @(negedge clk);
            lat++;
        end
        start = 1'b0;
        check("done_seen", 32'(done_o), 32'd1);
        check("done_latency", 32'(lat), 32'(v.exp_lat));
        check("write_count", 32'(n_writes - w0), 32'(v.exp_writes));
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        check("busy_at_done", 32'(busy_o), 32'd0);
        check("spell_rst_at_done", 32'(spell_rst_o), 32'd0);
        check("csb_at_done", 32'(flash_csb_o), 32'd1);
        check("crc_at_done", 32'(crc_o), 32'(crc));
        if (v.len == '0) begin
            check("len0_no_cs", 32'(cs_falls - cs0), 32'd0);
        end else begin
            check("one_cs_frame", 32'(cs_falls - cs0), 32'd1);
            check("mosi_cmd", spi_cmd, {8'h03, v.base});
        end
        exp_q.delete();
        @(negedge clk);
        check("done_one_cycle", 32'(done_o), 32'd0);
        check("spell_rst_after", 32'(spell_rst_o), 32'd0);
    endtask

    vec_t vecs[6];
    vec_t v;
    int   wcnt;
    int   w0;
    int   cyc;

    initial begin
        flash_img[24'h100000] = 8'hAA;
        flash_img[24'h100001] = 8'h55;
        flash_img[24'h100002] = 8'h01;
        flash_img[24'h100003] = 8'hFF;
        for (int i = 0; i < 9; i++) flash_img[24'h200000 + 24'(i)] = 8'h31 + 8'(i);

        vecs[0] = '{24'h100000, 9'd4,     4,   261, 0};
        vecs[1] = '{24'h000010, 9'd1,     1,   165, 0};
        vecs[2] = '{24'hABCDEF, 9'd3,     3,   229, 0};
        vecs[3] = '{24'h200000, 9'd9,     9,   421, 0};
        vecs[4] = '{24'h000000, 9'h1FF,   256, 8325, 0};
        vecs[5] = '{24'h5A5A5A, 9'd0,     0,   1,   0};

        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", 32'(busy_o), 32'd0);
        check("rst_done", 32'(done_o), 32'd0);
        check("rst_spell_rst", 32'(spell_rst_o), 32'd1);
        check("rst_mem_we", 32'(mem_we_o), 32'd0);
        check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
        check("rst_mem_wdata", 32'(mem_wdata_o), 32'd0);
        check("rst_csb", 32'(flash_csb_o), 32'd1);
        check("rst_sck", 32'(flash_clk_o), 32'd0);
        check("rst_mosi", 32'(flash_io0_o), 32'd0);
        check("rst_crc", 32'(crc_o), 32'd0);

        for (int i = 0; i < 6; i++) begin
            run_load(vecs[i]);
            if (i == 3) begin
`ifdef SPELL_LOADER_CRC_EN
                check("crc_123456789", 32'(crc_o), 32'hF4);
`else
                check("crc_disabled", 32'(crc_o), 32'h00);
`endif
            end
        end

        // Abort after 10 data bytes, then reload from byte 0.
        for (int i = 0; i < 20; i++) exp_q.push_back('{8'(i), flash_byte(24'h300000 + 24'(i))});
        w0 = n_writes;
        @(negedge clk);
        start     = 1'b1;
        base_addr = 24'h300000;
        len       = 9'd20;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while ((n_writes - w0) < 10 && cyc < TIMEOUT) begin
            @(posedge clk);
            cyc++;
        end
        wcnt = n_writes - w0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("abort_writes", 32'(wcnt), 32'd10);
        check("abort_csb", 32'(flash_csb_o), 32'd1);
        check("abort_sck", 32'(flash_clk_o), 32'd0);
        check("abort_busy", 32'(busy_o), 32'd0);
        check("abort_spell_rst", 32'(spell_rst_o), 32'd1);
        check("abort_mem_we", 32'(mem_we_o), 32'd0);
        rst = 1'b0;
        exp_q.delete();
        v = '{24'h300000, 9'd20, 20, 773, 0};
        run_load(v);

        // A second start mid-load must be ignored.
        v = '{24'h400000, 9'd6, 6, 325, 60};
        run_load(v);

        check("sck_low_while_csb_high", 32'(sck_bad), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
